outagu: RTL and testbench

OUTAGU -- requirements
Module: outagu

---
 rtl/outagu.sv | 200 ++++++++++++++++++++
 tb/tb_outagu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/outagu.sv
// Output address generation unit: walks a 4-deep loop nest (bit-plane, i0, i1, i2)
// and emits one registered write address per accepted step. Define OUTAGU_ERR_EN for the sticky err output.
module outagu #(
  parameter int BPREC    = 6,
  parameter int BDBANKA  = 15,
  parameter int BWLENGTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic [BPREC-1:0]    oprecision,
  input  logic [BDBANKA-1:0]  ostride0,
  input  logic [BDBANKA-1:0]  ostride1,
  input  logic [BDBANKA-1:0]  ostride2,
  input  logic [BWLENGTH-1:0] olength0,
  input  logic [BWLENGTH-1:0] olength1,
  input  logic [BWLENGTH-1:0] olength2,
  input  logic [BDBANKA-1:0]  obaseaddr,
  output logic [BDBANKA-1:0]  oaddr_out,
  output logic                we_out,
  output logic                busy,
  output logic                done
`ifdef OUTAGU_ERR_EN
  ,
  output logic                err
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [BPREC-1:0]    plast_q, plast_d, p_q, p_d;
  logic [BWLENGTH-1:0] l0last_q, l0last_d, l1last_q, l1last_d, l2last_q, l2last_d;
  logic [BWLENGTH-1:0] i0_q, i0_d, i1_q, i1_d, i2_q, i2_d;
  logic [BDBANKA-1:0]  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [BDBANKA-1:0]  addr_q, addr_d, ptr0_q, ptr0_d, ptr1_q, ptr1_d, ptr2_q, ptr2_d;
  logic [BDBANKA-1:0]  oaddr_q, oaddr_d;
  logic                we_q, we_d, done_q, done_d;
  logic [BDBANKA-1:0]  nxt;

  // ptrK holds the address of the first element at loop level K; addr_q is the
  // address of the next write. Lengths/precision are stored as "last index".
  always_comb begin
    state_d  = state_q;
    plast_d  = plast_q;
    l0last_d = l0last_q;
    l1last_d = l1last_q;
    l2last_d = l2last_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    p_d      = p_q;
    i0_d     = i0_q;
    i1_d     = i1_q;
    i2_d     = i2_q;
    addr_d   = addr_q;
    ptr0_d   = ptr0_q;
    ptr1_d   = ptr1_q;
    ptr2_d   = ptr2_q;
    oaddr_d  = oaddr_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    nxt      = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          plast_d  = (oprecision == '0) ? '0 : oprecision - BPREC'(1);
          l0last_d = (olength0 == '0) ? '0 : olength0 - BWLENGTH'(1);
          l1last_d = (olength1 == '0) ? '0 : olength1 - BWLENGTH'(1);
          l2last_d = (olength2 == '0) ? '0 : olength2 - BWLENGTH'(1);
          s0_d     = ostride0;
          s1_d     = ostride1;
          s2_d     = ostride2;
          p_d      = '0;
          i0_d     = '0;
          i1_d     = '0;
          i2_d     = '0;
          addr_d   = obaseaddr;
          ptr0_d   = obaseaddr;
          ptr1_d   = obaseaddr;
          ptr2_d   = obaseaddr;
        end
      end
      RUN: begin
        if (step) begin
          we_d    = 1'b1;
          oaddr_d = addr_q;
          if (p_q != plast_q) begin
            p_d    = p_q + BPREC'(1);
            addr_d = addr_q + BDBANKA'(1);
          end else begin
            p_d = '0;
            if (i0_q != l0last_q) begin
              i0_d   = i0_q + BWLENGTH'(1);
              nxt    = ptr0_q + s0_q;
              ptr0_d = nxt;
              addr_d = nxt;
            end else begin
              i0_d = '0;
              if (i1_q != l1last_q) begin
                i1_d   = i1_q + BWLENGTH'(1);
                nxt    = ptr1_q + s1_q;
                ptr1_d = nxt;
                ptr0_d = nxt;
                addr_d = nxt;
              end else begin
                i1_d = '0;
                if (i2_q != l2last_q) begin
                  i2_d   = i2_q + BWLENGTH'(1);
                  nxt    = ptr2_q + s2_q;
                  ptr2_d = nxt;
                  ptr1_d = nxt;
                  ptr0_d = nxt;
                  addr_d = nxt;
                end else begin
                  i2_d    = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      plast_q  <= '0;
      l0last_q <= '0;
      l1last_q <= '0;
      l2last_q <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      p_q      <= '0;
      i0_q     <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      addr_q   <= '0;
      ptr0_q   <= '0;
      ptr1_q   <= '0;
      ptr2_q   <= '0;
      oaddr_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      plast_q  <= plast_d;
      l0last_q <= l0last_d;
      l1last_q <= l1last_d;
      l2last_q <= l2last_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      p_q      <= p_d;
      i0_q     <= i0_d;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      addr_q   <= addr_d;
      ptr0_q   <= ptr0_d;
      ptr1_q   <= ptr1_d;
      ptr2_q   <= ptr2_d;
      oaddr_q  <= oaddr_d;
      we_q     <= we_d;
      done_q   <= done_d;
    end
  end

  assign oaddr_out = oaddr_q;
  assign we_out    = we_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);

`ifdef OUTAGU_ERR_EN
  logic err_q, err_d;

  // An accepted start clears the flag even if step is also high that cycle.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start)
      err_d = 1'b0;
    else if ((state_q == IDLE && step) || (state_q == RUN && start))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_outagu.sv
// Directed, table-driven bench for outagu: job table with hand-computed address lists,
// plus hand-written reset-abort and error-flag sequences.
module tb_outagu;

  logic        clk = 1'b0;
  logic        rst, start, step;
  logic [5:0]  oprecision;
  logic [14:0] ostride0, ostride1, ostride2, obaseaddr;
  logic [7:0]  olength0, olength1, olength2;
  logic [14:0] oaddr_out;
  logic        we_out, busy, done;
`ifdef OUTAGU_ERR_EN
  logic        err;
`endif

  outagu dut (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .oprecision(oprecision),
    .ostride0(ostride0), .ostride1(ostride1), .ostride2(ostride2),
    .olength0(olength0), .olength1(olength1), .olength2(olength2),
    .obaseaddr(obaseaddr),
    .oaddr_out(oaddr_out), .we_out(we_out), .busy(busy), .done(done)
`ifdef OUTAGU_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] base;
    logic [5:0]  prec;
    logic [7:0]  l0, l1, l2;
    logic [14:0] s0, s1, s2;
    logic        toggle;
    int          off;
    int          cnt;
  } vec_t;

  vec_t        vt [5];
  logic [14:0] exp_tab [0:20];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [14:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic run_job(input int v);
    int  n;
    bit  done_seen;
    bit  stp;
    obaseaddr  = vt[v].base;  oprecision = vt[v].prec;
    olength0   = vt[v].l0;    olength1   = vt[v].l1;    olength2 = vt[v].l2;
    ostride0   = vt[v].s0;    ostride1   = vt[v].s1;    ostride2 = vt[v].s2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // scramble config to prove it was latched at start
    obaseaddr = 15'h5555; oprecision = 6'd7; olength0 = 8'd9; olength1 = 8'd5;
    olength2  = 8'd3;     ostride0 = 15'h33;  ostride1 = 15'h77; ostride2 = 15'h111;
    chk("busy_after_start", busy, 1);
    chk("no_we_after_start", we_out, 0);
    n = 0; done_seen = 0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      stp  = vt[v].toggle ? (c % 2 == 0) : 1'b1;
      step = stp;
      @(negedge clk);
      chk("we_follows_step", we_out, stp);
      if (we_out) begin
        chk("addr", oaddr_out, (n < vt[v].cnt) ? exp_tab[vt[v].off + n] : 15'h7fff);
        chk("done_pos", done, (n == vt[v].cnt - 1));
        last_addr = oaddr_out;
        if (done) begin
          chk("busy_low_at_done", busy, 0);
          done_seen = 1;
        end
        n++;
      end else begin
        chk("addr_hold", oaddr_out, last_addr);
      end
    end
    step = 1'b0;
    if (!done_seen) chk("timeout_no_done", 0, 1);
    chk("write_count", n, vt[v].cnt);
  endtask

  initial begin
    exp_tab = '{15'h100, 15'h101, 15'h102, 15'h103, 15'h104, 15'h105,
                15'h108, 15'h109, 15'h10A, 15'h10B, 15'h10C, 15'h10D,
                15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001,
                15'h020,
                15'h000, 15'h001, 15'h010, 15'h011};
    vt[0] = '{base:15'h100, prec:6'd2, l0:8'd3, s0:15'd2, l1:8'd2, s1:15'd8, l2:8'd1, s2:15'd0,
              toggle:1'b0, off:0, cnt:12};
    vt[1] = '{base:15'h100, prec:6'd2, l0:8'd3, s0:15'd2, l1:8'd2, s1:15'd8, l2:8'd1, s2:15'd0,
              toggle:1'b1, off:0, cnt:12};
    vt[2] = '{base:15'h7FFE, prec:6'd4, l0:8'd1, s0:15'd0, l1:8'd1, s1:15'd0, l2:8'd1, s2:15'd0,
              toggle:1'b0, off:12, cnt:4};
    vt[3] = '{base:15'h020, prec:6'd0, l0:8'd0, s0:15'd5, l1:8'd0, s1:15'd6, l2:8'd0, s2:15'd7,
              toggle:1'b0, off:16, cnt:1};
    vt[4] = '{base:15'h000, prec:6'd1, l0:8'd2, s0:15'd1, l1:8'd1, s1:15'd0, l2:8'd2, s2:15'h10,
              toggle:1'b0, off:17, cnt:4};

    rst = 1'b1; start = 1'b0; step = 1'b0;
    oprecision = '0; ostride0 = '0; ostride1 = '0; ostride2 = '0;
    olength0 = '0; olength1 = '0; olength2 = '0; obaseaddr = '0;
    last_addr = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_oaddr", oaddr_out, 0);
    chk("rst_we", we_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_job(v);

`ifdef OUTAGU_ERR_EN
    chk("err_clear_initially", err, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("err_set_step_idle", err, 1);
    chk("step_idle_no_we", we_out, 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    run_job(3);
    chk("err_cleared_by_start", err, 0);
    // start while RUN: flagged and ignored
    obaseaddr = 15'h020; oprecision = 6'd0; olength0 = 8'd0; olength1 = 8'd0; olength2 = 8'd0;
    start = 1'b1;
    @(negedge clk);
    obaseaddr = 15'h444;
    @(negedge clk);
    start = 1'b0;
    chk("err_set_start_run", err, 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("run_start_ignored_addr", oaddr_out, 15'h020);
    chk("run_start_ignored_done", done, 1);
    last_addr = oaddr_out;
    @(negedge clk);
`endif

    // reset mid-job after five writes
    begin
      int n;
      obaseaddr = 15'h100; oprecision = 6'd2; olength0 = 8'd3; ostride0 = 15'd2;
      olength1 = 8'd2; ostride1 = 15'd8; olength2 = 8'd1; ostride2 = 15'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      step = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
        @(negedge clk);
        if (we_out) n++;
      end
      chk("five_writes_before_rst", n, 5);
      chk("addr_5th_write", oaddr_out, 15'h104);
      rst = 1'b1;
      #1;
      chk("abort_oaddr", oaddr_out, 0);
      chk("abort_we", we_out, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      last_addr = '0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("no_we_after_abort", we_out, 0);
        chk("idle_after_abort", busy, 0);
      end
      step = 1'b0;
      @(negedge clk);
    end

    run_job(3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
